// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Request/response handshake bundle between a memory initiator (core memory
//   stage) and mem_responder.
//   Request channel : req_valid/req_ready, req_write, req_size, req_unsigned,
//                     req_addr, req_wdata
//   Response channel: resp_valid/resp_ready, resp_rdata, resp_fault
//   master: initiator side, slave: responder side.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
//   Handshake-driven word-organised memory. Accepts one load/store at a time,
//   optionally waits WAIT_STATES cycles, performs the byte/half/word access
//   (or reports a fault without touching storage) and holds the response
//   until the initiator takes it.
//   Ports:
//     clk   : clock, all state changes on the rising edge
//     reset : asynchronous, active-low reset
//     bus   : mem_responder_if.slave (request and response channels)
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ADDR_BASE   = 32'h0
) (
    input logic            clk,
    input logic            reset,
    mem_responder_if.slave bus
);
    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WS_M1 = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESPOND} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            write_q, write_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [1:0]      lane_q, lane_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            fault_q, fault_d;   // captured request fault
    logic [31:0]     rdata_q, rdata_d;
    logic            rfault_q, rfault_d; // response fault flag

    logic [31:0]     mem_q [DEPTH_WORDS];

    // Offset from the storage base; an address below the base wraps to a
    // huge value and so lands out of range through the same compare.
    logic [31:0] req_off;
    logic        req_fault;
    assign req_off   = bus.req_addr - ADDR_BASE;
    assign req_fault = (bus.req_size == 2'b11)
                     | ((bus.req_size == 2'b01) & bus.req_addr[0])
                     | ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00))
                     | (req_off >= SPAN);

    // Storage access datapath.
    logic [31:0] rd_word, rd_shift, load_val, wr_data;
    logic [3:0]  wr_be;
    logic        mem_we;

    assign rd_word  = mem_q[idx_q];
    assign rd_shift = rd_word >> {lane_q, 3'b000};

    always_comb begin
        load_val = rd_word;
        wr_be    = 4'b1111;
        wr_data  = wdata_q;
        case (size_q)
            2'b00: begin
                load_val = uns_q ? {24'h0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
                wr_be    = 4'b0001 << lane_q;
                wr_data  = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                load_val = uns_q ? {16'h0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
                wr_be    = lane_q[1] ? 4'b1100 : 4'b0011;
                wr_data  = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    // Next-state and response logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        size_d   = size_q;
        uns_d    = uns_q;
        idx_d    = idx_q;
        lane_d   = lane_q;
        wdata_d  = wdata_q;
        fault_d  = fault_q;
        rdata_d  = rdata_q;
        rfault_d = rfault_q;
        mem_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    idx_d   = req_off[AW+1:2];
                    lane_d  = bus.req_addr[1:0];
                    wdata_d = bus.req_wdata;
                    fault_d = req_fault;
                    // Faulted requests skip the wait states entirely.
                    if (req_fault || WAIT_STATES == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS_M1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ACCESS: begin
                state_d  = S_RESPOND;
                rfault_d = fault_q;
                rdata_d  = 32'h0;
                if (!fault_q) begin
                    if (write_q) mem_we  = 1'b1;
                    else         rdata_d = load_val;
                end
            end
            S_RESPOND: begin
                if (bus.resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            write_q  <= 1'b0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            idx_q    <= '0;
            lane_q   <= 2'b00;
            wdata_q  <= 32'h0;
            fault_q  <= 1'b0;
            rdata_q  <= 32'h0;
            rfault_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            idx_q    <= idx_d;
            lane_q   <= lane_d;
            wdata_q  <= wdata_d;
            fault_q  <= fault_d;
            rdata_q  <= rdata_d;
            rfault_q <= rfault_d;
        end
    end

    // Storage is not reset. mem_we decodes from state_q, which reset clears
    // asynchronously, so a store caught by reset before its edge is dropped.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem_q[idx_q][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = (state_q == S_RESPOND);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_fault = rfault_q;
endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
    localparam int DEPTH = 1024;
    localparam int WS [3] = '{1, 0, 15};

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int          sel = 0;
    logic        tb_valid = 1'b0, tb_write = 1'b0, tb_uns = 1'b0, tb_rready = 1'b1;
    logic [1:0]  tb_size = 2'b00;
    logic [31:0] tb_addr = 32'h0, tb_wdata = 32'h0;

    mem_responder_if if0 ();
    mem_responder_if if1 ();
    mem_responder_if if2 ();

    assign if0.req_valid = tb_valid && (sel == 0);
    assign if1.req_valid = tb_valid && (sel == 1);
    assign if2.req_valid = tb_valid && (sel == 2);
    assign {if0.req_write, if0.req_size, if0.req_unsigned, if0.req_addr, if0.req_wdata, if0.resp_ready} = {tb_write, tb_size, tb_uns, tb_addr, tb_wdata, tb_rready};
    assign {if1.req_write, if1.req_size, if1.req_unsigned, if1.req_addr, if1.req_wdata, if1.resp_ready} = {tb_write, tb_size, tb_uns, tb_addr, tb_wdata, tb_rready};
    assign {if2.req_write, if2.req_size, if2.req_unsigned, if2.req_addr, if2.req_wdata, if2.resp_ready} = {tb_write, tb_size, tb_uns, tb_addr, tb_wdata, tb_rready};

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1),  .ADDR_BASE(32'h0)) u_ws1  (.clk(clk), .reset(reset), .bus(if0));
    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0),  .ADDR_BASE(32'h0)) u_ws0  (.clk(clk), .reset(reset), .bus(if1));
    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(15), .ADDR_BASE(32'h0)) u_ws15 (.clk(clk), .reset(reset), .bus(if2));

    // View of the currently selected responder.
    logic        rq_ready, rs_valid, rs_fault;
    logic [31:0] rs_rdata;
    always_comb begin
        case (sel)
            1:       {rq_ready, rs_valid, rs_fault, rs_rdata} = {if1.req_ready, if1.resp_valid, if1.resp_fault, if1.resp_rdata};
            2:       {rq_ready, rs_valid, rs_fault, rs_rdata} = {if2.req_ready, if2.resp_valid, if2.resp_fault, if2.resp_rdata};
            default: {rq_ready, rs_valid, rs_fault, rs_rdata} = {if0.req_ready, if0.resp_valid, if0.resp_fault, if0.resp_rdata};
        endcase
    end

    // Cycle stamps of accepted requests, for issue-interval checks.
    int cyc = 0;
    int acc_q[$];
    always @(posedge clk) begin
        if (tb_valid && rq_ready) acc_q.push_back(cyc);
        cyc <= cyc + 1;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference model: byte-addressed little-endian memory per responder.
    logic [7:0] mb [3][DEPTH*4];

    task automatic model_txn(input int k, input logic w, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rd, output logic f);
        int n;
        n  = 1 << size;
        f  = (size == 2'b11) || (addr % n != 0) || (addr >= DEPTH * 4);
        rd = 32'h0;
        if (!f) begin
            if (w) begin
                for (int i = 0; i < n; i++) mb[k][addr + i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) rd |= 32'(mb[k][addr + i]) << (8 * i);
                if (!uns && n < 4 && rd[8*n - 1]) rd |= ~((32'd1 << (8 * n)) - 32'd1);
            end
        end
    endtask

    // One complete transaction on the selected responder; lat counts edges
    // from the accepting edge to the edge that raised resp_valid.
    task automatic txn(input logic w, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic f, output int lat);
        int t;
        t = 0;
        @(negedge clk);
        while (!rq_ready && t < 50) begin @(negedge clk); t++; end
        if (!rq_ready) begin
            checks++; failures++;
            $display("FAIL req_ready_timeout actual=0 expected=1");
        end
        {tb_write, tb_size, tb_uns, tb_addr, tb_wdata} = {w, size, uns, addr, wdata};
        tb_valid = 1'b1;
        @(posedge clk); #1;
        tb_valid = 1'b0;
        lat = 0;
        while (!rs_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        if (!rs_valid) begin
            checks++; failures++;
            $display("FAIL resp_timeout actual=0 expected=1");
        end
        rd = rs_rdata;
        f  = rs_fault;
        if (tb_rready) begin @(posedge clk); #1; end
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_f;
        string       nm;
    } vec_t;

    task automatic run_vec(input int k, input vec_t v);
        logic [31:0] mrd, rd;
        logic        mf, f;
        int          lat;
        model_txn(k, v.w, v.size, v.uns, v.addr, v.wdata, mrd, mf);
        txn(v.w, v.size, v.uns, v.addr, v.wdata, rd, f, lat);
        chk({v.nm, "_rdata"}, rd, v.exp_rd);
        chk({v.nm, "_fault"}, 32'(f), 32'(v.exp_f));
        chk({v.nm, "_lat"}, 32'(lat), v.exp_f ? 32'd1 : 32'(WS[k] + 1));
    endtask

    task automatic rand_op(input int k, input logic [31:0] lo, input logic force_wr);
        logic        w, uns, mf, f;
        logic [1:0]  size;
        logic [31:0] addr, wdata, mrd, rd;
        int          lat;
        w     = force_wr ? 1'b1 : 1'($urandom_range(0, 1));
        size  = force_wr ? 2'b10 : (($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)));
        uns   = 1'($urandom_range(0, 1));
        wdata = $urandom;
        addr  = lo + 32'($urandom_range(0, 63));
        if (force_wr) addr = lo;
        else if ($urandom_range(0, 7) == 0) addr = ($urandom_range(0, 1) == 0) ? 32'h1000 + 32'($urandom_range(0, 255)) : 32'hFFFF_FFF0;
        model_txn(k, w, size, uns, addr, wdata, mrd, mf);
        txn(w, size, uns, addr, wdata, rd, f, lat);
        chk("rand_rdata", rd, mrd);
        chk("rand_fault", 32'(f), 32'(mf));
        chk("rand_lat", 32'(lat), mf ? 32'd1 : 32'(WS[k] + 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[$];
        logic [31:0] mrd, rd;
        logic        mf, f;
        int          lat, t;

        // Reset values on every build.
        #12;
        for (int k = 0; k < 3; k++) begin
            sel = k; #1;
            chk("rst_req_ready", 32'(rq_ready), 32'd1);
            chk("rst_resp_valid", 32'(rs_valid), 32'd0);
            chk("rst_resp_rdata", rs_rdata, 32'd0);
            chk("rst_resp_fault", 32'(rs_fault), 32'd0);
        end
        sel = 0;
        @(negedge clk); reset = 1'b1;

        // Directed vectors (WAIT_STATES=1 build).
        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, "st_w10"});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, "ld_w10"});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h20,   32'h11223344, 32'h0,        1'b0, "st_w20"});
        tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h21,   32'h000000F0, 32'h0,        1'b0, "st_b21"});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h21,   32'h0,        32'hFFFFFFF0, 1'b0, "ld_bs21"});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h21,   32'h0,        32'h000000F0, 1'b0, "ld_bu21"});
        tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h22,   32'h0,        32'h00001122, 1'b0, "ld_hs22"});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h20,   32'h0,        32'h1122F044, 1'b0, "ld_w20"});
        tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h22,   32'h12348001, 32'h0,        1'b0, "st_h22"});
        tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h22,   32'h0,        32'hFFFF8001, 1'b0, "ld_hs22b"});
        tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h22,   32'h0,        32'h00008001, 1'b0, "ld_hu22"});
        tbl.push_back('{1'b0, 2'd2, 1'b1, 32'h20,   32'h0,        32'h8001F044, 1'b0, "ld_w20b"});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h30,   32'h55667788, 32'h0,        1'b0, "st_w30"});
        tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h31,   32'h0,        32'h0,        1'b1, "flt_h31"});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h32,   32'hFFFFFFFF, 32'h0,        1'b1, "flt_w32"});
        tbl.push_back('{1'b1, 2'd3, 1'b0, 32'h30,   32'h0,        32'h0,        1'b1, "flt_sz3"});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,        32'h0,        1'b1, "flt_range"});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h30,   32'h0,        32'h55667788, 1'b0, "ld_w30"});
        foreach (tbl[i]) run_vec(0, tbl[i]);

        // Backpressure: response held stable while resp_ready stays low.
        tb_rready = 1'b0;
        model_txn(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, mrd, mf);
        txn(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, f, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_resp_valid", 32'(rs_valid), 32'd1);
            chk("bp_resp_rdata", rs_rdata, mrd);
            chk("bp_resp_fault", 32'(rs_fault), 32'd0);
            chk("bp_req_ready", 32'(rq_ready), 32'd0);
        end
        @(negedge clk); tb_rready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_req_ready", 32'(rq_ready), 32'd1);
        chk("bp_release_resp_valid", 32'(rs_valid), 32'd0);

        // Reset while a store waits; the store must never land.
        run_vec(0, '{1'b1, 2'd2, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, "st_w40_zero"});
        run_vec(0, '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "ld_w10_pre"});
        @(negedge clk);
        {tb_write, tb_size, tb_uns, tb_addr, tb_wdata} = {1'b1, 2'd2, 1'b0, 32'h40, 32'hAAAAAAAA};
        tb_valid = 1'b1;
        @(posedge clk); #1;
        tb_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("midrst_resp_valid", 32'(rs_valid), 32'd0);
        chk("midrst_resp_rdata", rs_rdata, 32'd0);
        chk("midrst_resp_fault", 32'(rs_fault), 32'd0);
        chk("midrst_req_ready", 32'(rq_ready), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        t = 0;
        repeat (4) begin @(posedge clk); #1; if (rs_valid) t++; end
        chk("midrst_no_resp", 32'(t), 32'd0);
        run_vec(0, '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, "ld_w40_after_rst"});

        // Latency and minimum issue interval on each build.
        for (int k = 0; k < 3; k++) begin
            sel = k;
            acc_q.delete();
            run_vec(k, '{1'b1, 2'd2, 1'b0, 32'h80, 32'hCAFE0000 | 32'(k), 32'h0, 1'b0, "lat_st"});
            run_vec(k, '{1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'hCAFE0000 | 32'(k), 1'b0, "lat_ld"});
            run_vec(k, '{1'b0, 2'd0, 1'b1, 32'h1000, 32'h0, 32'h0, 1'b1, "lat_flt"});
            if (acc_q.size() >= 3) begin
                chk("issue_interval", 32'(acc_q[1] - acc_q[0]), 32'(WS[k] + 3));
                chk("issue_interval_flt", 32'(acc_q[2] - acc_q[1]), 32'(WS[k] + 3));
            end else begin
                chk("accept_count", 32'(acc_q.size()), 32'd3);
            end
        end

        // Randomized traffic against the model on each build.
        for (int k = 0; k < 3; k++) begin
            sel = k;
            for (int i = 0; i < 16; i++) rand_op(k, 32'h200 + 32'(4 * i), 1'b1);
            for (int i = 0; i < (k == 0 ? 60 : 20); i++) rand_op(k, 32'h200, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
